// File: rtl/count_checker.sv
// rtl/count_checker.sv - receive-side integrity checker for a free-running counter stream
//
// Samples i_count on every enabled clock edge and checks that each sample is
// the previous sample plus one, modulo 2^WIDTH. The reference (o_expected)
// always re-seeds from the last observed value, so a single corrupted sample
// costs exactly one mismatch rather than a run of them.
//
// Lock is hysteretic: LOCK_COUNT consecutive matches are needed to lock, and
// LOSS_COUNT consecutive post-lock mismatches are needed to drop it. Only
// mismatches seen while locked (LOCKED or SLIPPING) are counted.
//
// Ports:
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_en         sample qualifier; low forces re-acquisition
//   i_count      observed count value
//   i_clr_err    synchronous clear of o_err_count (clear first, then increment)
//   o_locked     checker is locked to the stream (LOCKED or SLIPPING)
//   o_mismatch   one-cycle pulse per counted mismatch
//   o_err_count  saturating total of counted mismatches
//   o_expected   value expected at the next sample
module count_checker #(
  parameter int WIDTH      = 32,
  parameter int ERR_WIDTH  = 16,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_count,
  input  logic                 i_clr_err,
  output logic                 o_locked,
  output logic                 o_mismatch,
  output logic [ERR_WIDTH-1:0] o_err_count,
  output logic [WIDTH-1:0]     o_expected
);

  // Run counters only need to reach their thresholds.
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    LOCKED,
    SLIPPING
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         good_q, good_d, good_inc;
  logic [BW-1:0]         bad_q, bad_d, bad_inc;
  logic [WIDTH-1:0]      expected_q, expected_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d, err_base;
  logic                  locked_q, locked_d;
  logic                  mism_q, mism_d;
  logic                  match;
  logic                  count_err;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    expected_d = expected_q;
    count_err  = 1'b0;

    match    = (i_count == expected_q);
    good_inc = good_q + GW'(1);
    bad_inc  = bad_q + BW'(1);

    if (i_en) begin
      // Reference always re-seeds from what was actually observed.
      expected_d = i_count + WIDTH'(1);

      case (state_q)
        SEARCH: begin
          // First sample only seeds the reference; nothing to compare against.
          state_d = LOCKING;
          good_d  = '0;
        end

        LOCKING: begin
          if (match) begin
            if (good_inc == GW'(LOCK_COUNT)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end

        LOCKED: begin
          if (!match) begin
            count_err = 1'b1;
            if (LOSS_COUNT == 1) begin
              state_d = SEARCH;
              bad_d   = '0;
            end else begin
              state_d = SLIPPING;
              bad_d   = BW'(1);
            end
          end
        end

        SLIPPING: begin
          if (match) begin
            state_d = LOCKED;
            bad_d   = '0;
          end else begin
            count_err = 1'b1;
            if (bad_inc == BW'(LOSS_COUNT)) begin
              state_d = SEARCH;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end

        default: begin
          state_d = SEARCH;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end else begin
      // Disabled: forget the lock but keep the reference and the error total.
      state_d = SEARCH;
      good_d  = '0;
      bad_d   = '0;
    end

    // Clear takes effect before a same-cycle increment; counter sticks at all-ones.
    err_base = i_clr_err ? '0 : err_q;
    if (count_err && (err_base != '1)) begin
      err_d = err_base + ERR_WIDTH'(1);
    end else begin
      err_d = err_base;
    end

    locked_d = (state_d == LOCKED) || (state_d == SLIPPING);
    mism_d   = count_err;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      bad_q      <= '0;
      expected_q <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      mism_q     <= mism_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_mismatch  = mism_q;
  assign o_err_count = err_q;
  assign o_expected  = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking scoreboard bench for count_checker
module tb_count_checker;

  logic        i_clk;
  logic        i_rst;

  // Instance A: default parameters.
  logic        a_en, a_clr, a_lk, a_mm;
  logic [31:0] a_count, a_exp;
  logic [15:0] a_err;

  // Instance B: 8-bit bus, 4-bit error counter, very tolerant loss threshold.
  logic        b_en, b_clr, b_lk, b_mm;
  logic [7:0]  b_count, b_exp;
  logic [3:0]  b_err;

  count_checker u_dut_a (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (a_en),
    .i_count     (a_count),
    .i_clr_err   (a_clr),
    .o_locked    (a_lk),
    .o_mismatch  (a_mm),
    .o_err_count (a_err),
    .o_expected  (a_exp)
  );

  count_checker #(
    .WIDTH      (8),
    .ERR_WIDTH  (4),
    .LOCK_COUNT (4),
    .LOSS_COUNT (32)
  ) u_dut_b (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (b_en),
    .i_count     (b_count),
    .i_clr_err   (b_clr),
    .o_locked    (b_lk),
    .o_mismatch  (b_mm),
    .o_err_count (b_err),
    .o_expected  (b_exp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model. st: 0 search, 1 locking, 2 locked, 3 slipping.
  typedef struct {
    int     st;
    int     good;
    int     bad;
    longint expv;
    longint err;
    bit     mism;
  } mdl_t;

  typedef struct {
    bit     lk;
    bit     mm;
    longint err;
    longint ex;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } rec_t;

  mdl_t ma, mb;
  rec_t sbq[$];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.good = 0; m.bad = 0; m.expv = 0; m.err = 0; m.mism = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit en, longint cnt, bit clr,
                                 int w, int ew, int lc, int sc);
    mdl_t   n;
    longint mask;
    longint emax;
    bit     hit;
    bit     inc;
    n    = m;
    mask = (64'sd1 << w) - 1;
    emax = (64'sd1 << ew) - 1;
    inc  = 1'b0;
    n.mism = 1'b0;
    if (clr) n.err = 0;
    if (!en) begin
      n.st = 0; n.good = 0; n.bad = 0;
    end else begin
      hit    = ((cnt & mask) == m.expv);
      n.expv = (cnt + 1) & mask;
      case (m.st)
        0: begin n.st = 1; n.good = 0; end
        1: begin
          if (hit) begin
            n.good = m.good + 1;
            if (n.good >= lc) n.st = 2;
          end else n.good = 0;
        end
        2: begin
          if (!hit) begin
            inc = 1'b1; n.bad = 1;
            n.st = (sc == 1) ? 0 : 3;
          end
        end
        default: begin
          if (hit) begin
            n.st = 2; n.bad = 0;
          end else begin
            inc = 1'b1; n.bad = m.bad + 1;
            if (n.bad >= sc) n.st = 0;
          end
        end
      endcase
    end
    if (inc) begin
      n.mism = 1'b1;
      if (n.err < emax) n.err = n.err + 1;
    end
    return n;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.lk  = (m.st >= 2);
    e.mm  = m.mism;
    e.err = m.err;
    e.ex  = m.expv;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, push the expected outcome.
  task automatic step(input bit sel, input bit en, input longint cnt, input bit clr);
    rec_t r;
    if (!sel) begin
      a_en = en; a_count = cnt[31:0]; a_clr = clr;
      b_en = 1'b0; b_clr = 1'b0;
      ma = mstep(ma, en, cnt, clr, 32, 16, 4, 2);
      mb = mstep(mb, 1'b0, 0, 1'b0, 8, 4, 4, 32);
    end else begin
      b_en = en; b_count = cnt[7:0]; b_clr = clr;
      a_en = 1'b0; a_clr = 1'b0;
      mb = mstep(mb, en, cnt, clr, 8, 4, 4, 32);
      ma = mstep(ma, 1'b0, 0, 1'b0, 32, 16, 4, 2);
    end
    r.a = to_exp(ma);
    r.b = to_exp(mb);
    sbq.push_back(r);
    @(negedge i_clk);
  endtask

  // Scoreboard consumer: compare outputs just after each rising edge.
  rec_t mon_r;
  always begin
    @(posedge i_clk);
    #1;
    if (sbq.size() > 0) begin
      mon_r = sbq.pop_front();
      check("a.locked",   a_lk,  mon_r.a.lk);
      check("a.mismatch", a_mm,  mon_r.a.mm);
      check("a.err",      a_err, mon_r.a.err);
      check("a.expected", a_exp, mon_r.a.ex);
      check("b.locked",   b_lk,  mon_r.b.lk);
      check("b.mismatch", b_mm,  mon_r.b.mm);
      check("b.err",      b_err, mon_r.b.err);
      check("b.expected", b_exp, mon_r.b.ex);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, ".a.locked"},   a_lk,  0);
    check({tag, ".a.mismatch"}, a_mm,  0);
    check({tag, ".a.err"},      a_err, 0);
    check({tag, ".a.expected"}, a_exp, 0);
    check({tag, ".b.locked"},   b_lk,  0);
    check({tag, ".b.mismatch"}, b_mm,  0);
    check({tag, ".b.err"},      b_err, 0);
    check({tag, ".b.expected"}, b_exp, 0);
  endtask

  int mseen;

  initial begin
    i_rst = 1'b0;
    a_en = 1'b0; a_count = '0; a_clr = 1'b0;
    b_en = 1'b0; b_count = '0; b_clr = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    mseen = 0;

    #1 i_rst = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Clean acquisition from 0 on instance A.
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, i, 1'b0);
      if (i == 3) check("acq_before_edge5", a_lk, 0);
      if (i == 4) check("acq_after_edge5", a_lk, 1);
      if (a_mm) mseen++;
    end
    check("clean_mismatch_seen", mseen, 0);
    check("clean_err", a_err, 0);

    // Single glitch: re-acquire on 5..9, then 10, 11, 99, 100, 101.
    step(1'b0, 1'b0, 0, 1'b0);
    for (int v = 5; v <= 11; v++) step(1'b0, 1'b1, v, 1'b0);
    check("glitch_locked_pre", a_lk, 1);
    step(1'b0, 1'b1, 99, 1'b0);
    check("glitch_pulse", a_mm, 1);
    check("glitch_err", a_err, 1);
    check("glitch_locked_slip", a_lk, 1);
    step(1'b0, 1'b1, 100, 1'b0);
    check("glitch_pulse_once", a_mm, 0);
    check("glitch_locked_back", a_lk, 1);
    step(1'b0, 1'b1, 101, 1'b0);
    check("glitch_err_final", a_err, 1);
    check("glitch_locked_final", a_lk, 1);

    // Loss and relock; clear issued while disabled.
    step(1'b0, 1'b0, 0, 1'b1);
    check("clr_while_disabled", a_err, 0);
    for (int v = 5; v <= 11; v++) step(1'b0, 1'b1, v, 1'b0);
    step(1'b0, 1'b1, 50, 1'b0);
    check("loss_locked_after_50", a_lk, 1);
    check("loss_err_after_50", a_err, 1);
    step(1'b0, 1'b1, 70, 1'b0);
    check("loss_locked_after_70", a_lk, 0);
    check("loss_err_after_70", a_err, 2);
    for (int v = 71; v <= 74; v++) step(1'b0, 1'b1, v, 1'b0);
    check("relock_after_74", a_lk, 0);
    step(1'b0, 1'b1, 75, 1'b0);
    check("relock_after_75", a_lk, 1);
    check("relock_err", a_err, 2);

    // Enable drop for 3 cycles while locked.
    repeat (3) step(1'b0, 1'b0, 12345, 1'b0);
    check("en_low_locked", a_lk, 0);
    check("en_low_err_held", a_err, 2);
    check("en_low_expected_held", a_exp, 76);
    for (int v = 200; v <= 203; v++) step(1'b0, 1'b1, v, 1'b0);
    check("en_relock_after_4", a_lk, 0);
    step(1'b0, 1'b1, 204, 1'b0);
    check("en_relock_after_5", a_lk, 1);

    // Asynchronous reset mid-lock, checked before any clock edge.
    #2 i_rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge i_clk);
    i_rst = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();

    // Wrap-around on the 8-bit instance.
    for (int v = 240; v <= 255; v++) begin
      step(1'b1, 1'b1, v, 1'b0);
      if (v == 243) check("wrap_lock_pre", b_lk, 0);
      if (v == 244) check("wrap_lock", b_lk, 1);
      if (v == 254) check("wrap_exp_255", b_exp, 255);
    end
    check("wrap_exp_0", b_exp, 0);
    step(1'b1, 1'b1, 0, 1'b0);
    check("wrap_exp_1", b_exp, 1);
    check("wrap_no_pulse", b_mm, 0);
    step(1'b1, 1'b1, 1, 1'b0);
    step(1'b1, 1'b1, 2, 1'b0);
    check("wrap_err", b_err, 0);
    check("wrap_locked", b_lk, 1);

    // Saturation: 20 alternating bad values, then clear on a mismatch cycle.
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, (k % 2) ? 64'h55 : 64'hAA, 1'b0);
      check("sat_pulse", b_mm, 1);
      check("sat_err", b_err, (k < 15) ? k : 15);
      check("sat_locked", b_lk, 1);
    end
    step(1'b1, 1'b1, 64'h55, 1'b1);
    check("clr_with_mismatch_err", b_err, 1);
    check("clr_with_mismatch_pulse", b_mm, 1);
    step(1'b1, 1'b1, 64'h56, 1'b1);
    check("clr_alone_err", b_err, 0);
    check("clr_alone_pulse", b_mm, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Receive-side checker for the free-running counter stream. Samples a WIDTH-bit count bus each enabled cycle and verifies that every sample equals the previous sample plus one, modulo 2^WIDTH. Lock acquisition and loss are hysteretic. Post-lock mismatches are reported as a pulse and in a saturating error counter. Sits at the consumer end of any count bus, as an on-chip integrity monitor or bench self-check.

## Interface
- WIDTH, 32, count bus width (>=2)
- ERR_WIDTH, 16, error counter width (>=1)
- LOCK_COUNT, 4, consecutive matches needed to lock (>=1)
- LOSS_COUNT, 2, consecutive post-lock mismatches needed to drop lock (>=1)

- i_clk  in  1  clock
- i_rst  in  1  reset: asynchronous, active-high
- i_en  in  1  sample qualifier; low forces re-acquisition
- i_count  in  WIDTH  observed count
- i_clr_err  in  1  synchronous clear of o_err_count
- o_locked  out  1  checker is locked to the stream
- o_mismatch  out  1  one-cycle pulse per counted mismatch
- o_err_count  out  ERR_WIDTH  saturating mismatch total
- o_expected  out  WIDTH  value expected at the next sample

## Operation
- Reset values:
  - state: SEARCH.
  - o_locked, o_mismatch, o_err_count, o_expected: all 0.
  - Internal good/bad run counters: 0.
- Sample = a rising edge with i_en=1.
- Match = i_count == o_expected. Compare is WIDTH-bit, so 2^WIDTH-1 -> 0 is a match.
- Every sample loads o_expected <= i_count + 1, truncated to WIDTH.
- The reference therefore always re-seeds from the last observed value.
- States:
  - SEARCH: any sample -> LOCKING, good=0. No compare is made.
  - LOCKING: match -> good+1; when good reaches LOCK_COUNT -> LOCKED. Mismatch -> good=0, stay. No error is counted.
  - LOCKED: match -> stay. Mismatch -> o_mismatch pulse, error increment, bad=1. Then -> SEARCH if LOSS_COUNT==1, else -> SLIPPING.
  - SLIPPING: match -> LOCKED, bad=0. Mismatch -> pulse, increment, bad+1; when bad reaches LOSS_COUNT -> SEARCH.
- o_locked = 1 in LOCKED and SLIPPING.
- i_en=0 at an edge:
  - state -> SEARCH; good and bad cleared.
  - o_expected and o_err_count held.
  - o_mismatch = 0.
- o_err_count behaviour:
  - Increments by 1 per counted mismatch.
  - Saturates at all-ones; holds there, with no wrap.
  - o_mismatch still pulses while saturated.
- i_clr_err=1 sets o_err_count to 0, plus 1 if a counted mismatch occurs in the same cycle (clear first, then increment). Works regardless of i_en.
- i_rst mid-operation returns all state and outputs to reset values immediately (asynchronous).

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- o_mismatch is high for exactly the one cycle after the edge that sampled the bad value.
- o_locked rises after the edge that takes the LOCK_COUNT-th consecutive match.
- Acquisition with a clean stream: 1 seed sample + LOCK_COUNT samples, i.e. o_locked is high after edge LOCK_COUNT+1.
- o_locked falls after the edge that takes the LOSS_COUNT-th consecutive post-lock mismatch.
- o_expected is valid the cycle after each sample.

## Test plan
- **Clean acquisition.** Defaults; counter feeds i_count from 0 after reset; i_en=1.
  - o_locked rises after edge 5.
  - o_mismatch never asserts; o_err_count = 0 after 1000 cycles.
- **Wrap-around.** WIDTH=8; drive 250..255, 0, 1, 2 continuously after lock.
  - No mismatch.
  - o_expected steps 255 -> 0 -> 1.
- **Single glitch.** LOSS_COUNT=2, locked; drive 10, 11, 99, 100, 101.
  - One o_mismatch pulse; o_err_count = 1.
  - o_locked stays 1 (SLIPPING then LOCKED).
- **Loss and relock.** LOSS_COUNT=2, locked; drive 10, 11, 50, 70, 71, 72, 73, 74, 75.
  - o_err_count = 2; o_locked falls after the 70 sample.
  - Relock after 75 (seed 71 + 4 matches); o_locked = 1.
- **Saturation and clear.** ERR_WIDTH=4, LOSS_COUNT=32, locked; drive 20 alternating bad values.
  - o_err_count sticks at 15; o_mismatch still pulses.
  - Assert i_clr_err on the cycle of a further mismatch -> o_err_count = 1.
- **Enable and reset.**
  - Drop i_en for 3 cycles while locked -> o_locked = 0, o_err_count held; with i_en back on a clean stream -> relock after 5 samples.
  - Assert i_rst mid-lock -> all outputs 0 without waiting for a clock edge.
